mdu_ctrl: RTL and testbench

//   Multiply/divide unit controller for the 5-stage pipeline. Sits beside the EX stage.

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit bus: EX-side request, HI/LO readback, stall.
// master = EX/hazard side, slave = mdu_ctrl.
interface mdu_ctrl_if;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        id_md_use;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_md;

   modport master (
      output start, md_op, rs_val, rt_val, id_md_use,
      input  busy, hi, lo, stall_md
   );

   modport slave (
      input  start, md_op, rs_val, rt_val, id_md_use,
      output busy, hi, lo, stall_md
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; MTHI/MTLO; ID stall request.
// Ports: clk, reset (async, active-low), md (mdu_ctrl_if.slave).
// Optional MADD/MADDU accumulate enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  md
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sgn_q, sgn_d;
   logic          div_q, div_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
`ifdef MDU_MADD_EN
   logic [63:0]   acc_q, acc_d;
`endif

   logic op_mul, op_div, op_mthi, op_mtlo, op_multi;

   always_comb begin
      op_mul  = (md.md_op[3:1] == 3'b000);
`ifdef MDU_MADD_EN
      op_mul  = op_mul | (md.md_op[3:1] == 3'b011);
`endif
      op_div   = (md.md_op[3:1] == 3'b001);
      op_mthi  = (md.md_op == 4'd4);
      op_mtlo  = (md.md_op == 4'd5);
      op_multi = op_mul | op_div;
   end

   // Datapath works only on latched operands.
   // Sign-extending to 64 bits lets one multiplier serve both signednesses.
   logic        a_neg, b_neg, b_zero;
   logic [31:0] a_mag, b_mag, dvsr;
   logic [31:0] q_mag, r_mag, quo, rem;
   logic [63:0] prod, mul_res;

   always_comb begin
      a_neg  = sgn_q & a_q[31];
      b_neg  = sgn_q & b_q[31];
      prod   = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
      a_mag  = a_neg ? -a_q : a_q;
      b_mag  = b_neg ? -b_q : b_q;
      b_zero = (b_q == 32'd0);
      dvsr   = b_zero ? 32'd1 : b_mag;
      // 0x80000000 / -1 falls out naturally: magnitude 2^31 / 1.
      q_mag  = a_mag / dvsr;
      r_mag  = a_mag % dvsr;
      quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem    = a_neg ? -r_mag : r_mag;
`ifdef MDU_MADD_EN
      mul_res = acc_q + prod;
`else
      mul_res = prod;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      div_d   = div_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MDU_MADD_EN
      acc_d   = acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (md.start) begin
               unique case (1'b1)
                  op_mul: begin
                     state_d = S_BUSY;
                     cnt_d   = MUL_LD;
                     div_d   = 1'b0;
                  end
                  op_div: begin
                     state_d = S_BUSY;
                     cnt_d   = DIV_LD;
                     div_d   = 1'b1;
                  end
                  op_mthi: hi_d = md.rs_val;
                  op_mtlo: lo_d = md.rs_val;
                  default: ;
               endcase
               if (op_multi) begin
                  a_d   = md.rs_val;
                  b_d   = md.rt_val;
                  sgn_d = ~md.md_op[0];
`ifdef MDU_MADD_EN
                  // Plain MULT accumulates onto zero.
                  acc_d = md.md_op[2] ? {hi_q, lo_q} : 64'd0;
`endif
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               if (div_q) begin
                  if (!b_zero) begin
                     hi_d = rem;
                     lo_d = quo;
                  end
               end else begin
                  {hi_d, lo_d} = mul_res;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         div_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_MADD_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         div_q   <= div_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MDU_MADD_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign md.busy     = (state_q == S_BUSY);
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;
   // Covers the start cycle so a following MD op never slips past ID.
   assign md.stall_md = md.id_md_use & (md.busy | (md.start & op_multi));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed table, corner sequences, random vs model.
// Honours MDU_MADD_EN for ops 6/7.
module tb_mdu_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (rst_n),
      .md    (bus)
   );

`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: remaining busy cycles plus pending result.
   int          m_left;
   logic [31:0] m_hi, m_lo;
   logic [63:0] p_res;
   bit          p_wr;

   function automatic bit is_multi(input logic [3:0] op);
      return (op <= 4'd3) || (MADD && (op == 4'd6 || op == 4'd7));
   endfunction

   function automatic bit md_calc(input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [63:0] r);
      longint sa, sb, q, rm;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = {h, l};
      md_calc = 1'b1;
      case (op)
         4'd0: r = sa * sb;
         4'd1: r = ua * ub;
         4'd2: begin
            if (b == 32'd0) md_calc = 1'b0;
            else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = {rm[31:0], q[31:0]};
            end
         end
         4'd3: begin
            if (b == 32'd0) md_calc = 1'b0;
            else r = {32'(ua % ub), 32'(ua / ub)};
         end
         4'd6: r = {h, l} + 64'(sa * sb);
         4'd7: r = {h, l} + 64'(ua * ub);
         default: md_calc = 1'b0;
      endcase
   endfunction

   task automatic model_edge(input bit st, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) {m_hi, m_lo} = p_res;
      end else if (st) begin
         if (is_multi(op)) begin
            p_wr   = md_calc(op, a, b, m_hi, m_lo, r);
            p_res  = r;
            m_left = (op == 4'd2 || op == 4'd3) ? 10 : 5;
         end else if (op == 4'd4) begin
            m_hi = a;
         end else if (op == 4'd5) begin
            m_lo = a;
         end
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input bit st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit use_md);
      bus.start     = st;
      bus.md_op     = op;
      bus.rs_val    = a;
      bus.rt_val    = b;
      bus.id_md_use = use_md;
   endtask

   // Issue one op, scramble operands, count busy cycles (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cycles);
      @(negedge clk);
      drive(1'b1, op, a, b, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'hF, $urandom, $urandom, 1'b0);
      cycles = 0;
      while (bus.busy && cycles < 64) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t tbl[$];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int cyc;
      bit st;
      bit use_md;
      logic [3:0] op;
      logic [31:0] a, b;

      tbl.push_back('{"mult_neg",  4'd0, 32'hFFFF_FFFE, 32'd3,
                      32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
      tbl.push_back('{"multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001, 5});
      tbl.push_back('{"div_neg",   4'd2, 32'hFFFF_FFF9, 32'd2,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
      tbl.push_back('{"div_ovf",   4'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'h0, 32'h8000_0000, 10});
      tbl.push_back('{"divu_zero", 4'd3, 32'd7, 32'd0,
                      32'h0, 32'h8000_0000, 10});
      tbl.push_back('{"divu",      4'd3, 32'd100, 32'd7,
                      32'd2, 32'd14, 10});
      tbl.push_back('{"div_negd",  4'd2, 32'd7, 32'hFFFF_FFFE,
                      32'd1, 32'hFFFF_FFFD, 10});
      tbl.push_back('{"mult_min",  4'd0, 32'h8000_0000, 32'h8000_0000,
                      32'h4000_0000, 32'h0, 5});
      tbl.push_back('{"mthi",      4'd4, 32'h1234_ABCD, 32'd0,
                      32'h1234_ABCD, 32'h0, 0});
      tbl.push_back('{"mtlo",      4'd5, 32'h0000_1234, 32'd0,
                      32'h1234_ABCD, 32'h0000_1234, 0});
      tbl.push_back('{"noop9",     4'd9, 32'd5, 32'd5,
                      32'h1234_ABCD, 32'h0000_1234, 0});
      if (MADD) begin
         tbl.push_back('{"madd",   4'd6, 32'd2, 32'd3,
                         32'h1234_ABCD, 32'h0000_123A, 5});
         tbl.push_back('{"mthi0",  4'd4, 32'd0, 32'd0,
                         32'h0, 32'h0000_123A, 0});
         tbl.push_back('{"mtlo_f", 4'd5, 32'hFFFF_FFFF, 32'd0,
                         32'h0, 32'hFFFF_FFFF, 0});
         tbl.push_back('{"maddu",  4'd7, 32'd1, 32'd1,
                         32'd1, 32'd0, 5});
      end else begin
         tbl.push_back('{"op6_off", 4'd6, 32'd2, 32'd3,
                         32'h1234_ABCD, 32'h0000_1234, 0});
         tbl.push_back('{"op7_off", 4'd7, 32'd2, 32'd3,
                         32'h1234_ABCD, 32'h0000_1234, 0});
      end

      // Reset state.
      rst_n = 1'b0;
      drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_stall", 64'(bus.stall_md), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
         chk({tbl[i].name, "_cyc"}, 64'(cyc), 64'(tbl[i].cyc));
         chk({tbl[i].name, "_hi"}, 64'(bus.hi), 64'(tbl[i].hi));
         chk({tbl[i].name, "_lo"}, 64'(bus.lo), 64'(tbl[i].lo));
      end

      // Reset mid-DIV with cnt at 4.
      @(negedge clk);
      drive(1'b1, 4'd2, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
      repeat (5) @(negedge clk);
      chk("middiv_busy_pre", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("middiv_busy", 64'(bus.busy), 64'd0);
      chk("middiv_hi", 64'(bus.hi), 64'd0);
      chk("middiv_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd1, 32'd3, 32'd4, cyc);
      chk("post_rst_cyc", 64'(cyc), 64'd5);
      chk("post_rst_lo", 64'(bus.lo), 64'd12);
      chk("post_rst_hi", 64'(bus.hi), 64'd0);

      // Stall window of a MULT, with a start injected while busy.
      @(negedge clk);
      drive(1'b1, 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
      #1;
      chk("stall_start", 64'(bus.stall_md), 64'd1);
      @(negedge clk);
      drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) drive(1'b1, 4'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
         else drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
         #1;
         chk($sformatf("stall_busy%0d", k), 64'(bus.stall_md), 64'd1);
         chk($sformatf("busy%0d", k), 64'(bus.busy), 64'd1);
         @(negedge clk);
      end
      drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
      #1;
      chk("stall_fall", 64'(bus.stall_md), 64'd0);
      chk("busy_fall", 64'(bus.busy), 64'd0);
      chk("stall_mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      chk("stall_mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);
      @(negedge clk);
      drive(1'b1, 4'd5, 32'h0000_1234, 32'd0, 1'b1);
      #1;
      chk("mtlo_stall", 64'(bus.stall_md), 64'd0);
      @(negedge clk);
      drive(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
      #1;
      chk("mtlo_busy", 64'(bus.busy), 64'd0);
      chk("mtlo_lo", 64'(bus.lo), 64'h1234);

      // Random stimulus against the model.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      p_res  = '0;
      p_wr   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         st     = ($urandom % 3) == 0;
         op     = 4'($urandom % 16);
         a      = pick();
         b      = pick();
         use_md = $urandom % 2;
         drive(st, op, a, b, use_md);
         #1;
         chk("rnd_stall", 64'(bus.stall_md),
             64'(use_md && (m_left > 0 || (st && is_multi(op)))));
         @(posedge clk);
         model_edge(st, op, a, b);
         #1;
         chk("rnd_busy", 64'(bus.busy), 64'(m_left > 0));
         chk("rnd_hi", 64'(bus.hi), 64'(m_hi));
         chk("rnd_lo", 64'(bus.lo), 64'(m_lo));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
